// File: rtl/router_pkg.sv
// router_pkg: shared widths, header layout and helpers for the router register stage
package router_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int LEN_W      = 6;
  localparam int ADDR_W     = 2;
  localparam int ADDR_LSB   = 0;
  localparam int LEN_LSB    = 2;
  localparam int CNT_W      = LEN_W + 1;
  // header byte: payload length in [7:2], destination address in [1:0]
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } hdr_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/router_reg_if.sv
// router_reg_if: FSM strobes, source byte and FIFO write bus around router_reg
//   master: router_fsm/source side (drives strobes and data_in, reads status)
//   slave : router_reg (reads strobes and data_in, drives dout and status)
interface router_reg_if;
  import router_pkg::*;
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_pkt_valid;
  logic                  err;
  logic                  len_err;
  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err, len_err
  );
  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err, len_err
  );
endinterface

// File: rtl/router_parity_chk.sv
// router_parity_chk: XOR parity / payload count accumulation and end-of-packet check
//   clock, reset     : clock and synchronous active-high reset
//   clr_i            : detect_add, starts a new packet
//   lfd_i/ld_i/laf_i/full_state_i : FSM state strobes
//   pkt_valid_i, fifo_full_i, data_i : source byte qualifiers and byte
//   header_i, full_byte_i : latched header and byte held during full
//   parity_done_i, pd_rise_i : parity_done level and its rising edge
//   err_o, len_err_o : parity and length mismatch flags
module router_parity_chk
  import router_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  lfd_i,
  input  logic                  ld_i,
  input  logic                  laf_i,
  input  logic                  full_state_i,
  input  logic                  pkt_valid_i,
  input  logic                  fifo_full_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  hdr_t                  header_i,
  input  logic [DATA_WIDTH-1:0] full_byte_i,
  input  logic                  parity_done_i,
  input  logic                  pd_rise_i,
  output logic                  err_o,
  output logic                  len_err_o
);
  logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d, pkt_parity_q, pkt_parity_d;
  logic [CNT_W-1:0]      pay_cnt_q, pay_cnt_d;
  logic                  chk_pend_q, chk_pend_d, err_q, err_d, len_err_q, len_err_d;
  logic                  acc_ld, acc_laf;
  // a byte accepted while the FIFO was full is folded in later, when LAF replays it
  assign acc_ld  = ld_i && pkt_valid_i && !full_state_i && !fifo_full_i;
  assign acc_laf = laf_i && !parity_done_i;
  always_comb begin
    int_parity_d = clr_i ? '0 :
                   lfd_i ? int_parity_q ^ header_i :
                   acc_ld ? int_parity_q ^ data_i :
                   acc_laf ? int_parity_q ^ full_byte_i : int_parity_q;
    pay_cnt_d    = clr_i ? '0 :
                   (!lfd_i && (acc_ld || acc_laf)) ? sat_inc(pay_cnt_q) : pay_cnt_q;
    pkt_parity_d = (ld_i && !pkt_valid_i) ? data_i : pkt_parity_q;
    chk_pend_d   = pd_rise_i;
    err_d        = clr_i ? 1'b0 : chk_pend_q ? (int_parity_q != pkt_parity_q) : err_q;
    len_err_d    = clr_i ? 1'b0 : chk_pend_q ? (pay_cnt_q != {1'b0, header_i.len}) : len_err_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      int_parity_q <= '0;
      pkt_parity_q <= '0;
      pay_cnt_q    <= '0;
      chk_pend_q   <= 1'b0;
      err_q        <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      int_parity_q <= int_parity_d;
      pkt_parity_q <= pkt_parity_d;
      pay_cnt_q    <= pay_cnt_d;
      chk_pend_q   <= chk_pend_d;
      err_q        <= err_d;
      len_err_q    <= len_err_d;
    end
  end
  assign err_o     = err_q;
  assign len_err_o = len_err_q;
endmodule

// File: rtl/router_reg.sv
// router_reg: router datapath register stage between router_fsm and the FIFOs
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : FSM strobes, source byte, fifo_full in; dout, parity_done,
//                  low_pkt_valid, err, len_err out
module router_reg
  import router_pkg::*;
(
  input logic         clock,
  input logic         reset,
  router_reg_if.slave bus
);
  hdr_t                  header_q, header_d;
  logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d, dout_q, dout_d;
  logic                  parity_done_q, parity_done_d, low_pkt_valid_q, low_pkt_valid_d;
  logic                  pd_set;
  // parity ends either on a direct LD parity byte or when LAF drains a packet whose
  // pkt_valid already fell while the FIFO was full
  assign pd_set = (bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                  (bus.laf_state && low_pkt_valid_q && !parity_done_q);
  always_comb begin
    header_d        = (bus.detect_add && bus.pkt_valid) ? hdr_t'(bus.data_in) : header_q;
    full_byte_d     = (!bus.lfd_state && bus.ld_state && bus.fifo_full) ? bus.data_in : full_byte_q;
    dout_d          = bus.lfd_state ? header_q :
                      bus.ld_state ? (bus.fifo_full ? dout_q : bus.data_in) :
                      bus.laf_state ? full_byte_q : dout_q;
    parity_done_d   = bus.detect_add ? 1'b0 : pd_set ? 1'b1 : parity_done_q;
    low_pkt_valid_d = bus.rst_int_reg ? 1'b0 :
                      (bus.ld_state && !bus.pkt_valid) ? 1'b1 : low_pkt_valid_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      header_q        <= '0;
      full_byte_q     <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      header_q        <= header_d;
      full_byte_q     <= full_byte_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end
  router_parity_chk u_chk (
    .clock        (clock),
    .reset        (reset),
    .clr_i        (bus.detect_add),
    .lfd_i        (bus.lfd_state),
    .ld_i         (bus.ld_state),
    .laf_i        (bus.laf_state),
    .full_state_i (bus.full_state),
    .pkt_valid_i  (bus.pkt_valid),
    .fifo_full_i  (bus.fifo_full),
    .data_i       (bus.data_in),
    .header_i     (header_q),
    .full_byte_i  (full_byte_q),
    .parity_done_i(parity_done_q),
    .pd_rise_i    (parity_done_d && !parity_done_q),
    .err_o        (bus.err),
    .len_err_o    (bus.len_err)
  );
  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: packet-level randomized and directed checks of router_reg
module tb_router_reg;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  router_reg_if bus();
  router_reg dut (.clock(clock), .reset(reset), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] pay [256];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic idle;
    bus.detect_add = 0; bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0;
    bus.full_state = 0; bus.rst_int_reg = 0; bus.fifo_full = 0;
  endtask
  function automatic logic [7:0] good_par(input logic [7:0] hdr, input int n);
    logic [7:0] x = hdr;
    for (int i = 0; i < n; i++) x ^= pay[i];
    return x;
  endfunction
  // Drives one packet the way router_fsm sequences it; expectations come from the
  // packet contents: parity = XOR of header and payload, length = payload count.
  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par, input int full_at);
    logic [7:0] prev;
    int c;
    idle(); bus.detect_add = 1; bus.pkt_valid = 1; bus.data_in = hdr; step();
    idle();
    chk("clr_pd", bus.parity_done, 0);
    chk("clr_err", bus.err, 0);
    chk("clr_len_err", bus.len_err, 0);
    bus.lfd_state = 1; bus.data_in = 8'hA5; step(); idle();
    chk("dout_hdr", bus.dout, hdr);
    prev = hdr;
    for (int i = 0; i < n; i++) begin
      bus.pkt_valid = 1; bus.data_in = pay[i];
      if (i == full_at) begin
        bus.ld_state = 1; bus.fifo_full = 1; step();
        chk("dout_hold_full", bus.dout, prev);
        bus.ld_state = 0; bus.full_state = 1; step();
        bus.full_state = 0; bus.fifo_full = 0; bus.laf_state = 1; step(); idle();
        chk("dout_laf", bus.dout, pay[i]);
      end else begin
        bus.ld_state = 1; step(); idle();
        chk("dout_pay", bus.dout, pay[i]);
      end
      prev = pay[i];
    end
    bus.ld_state = 1; bus.pkt_valid = 0; bus.data_in = par; step(); idle();
    chk("dout_par", bus.dout, par);
    chk("pd_set", bus.parity_done, 1);
    chk("lpv_set", bus.low_pkt_valid, 1);
    chk("err_not_yet", bus.err, 0);
    bus.rst_int_reg = 1; step(); idle();
    c = (n > 127) ? 127 : n;
    chk("lpv_clr", bus.low_pkt_valid, 0);
    chk("err", bus.err, good_par(hdr, n) != par);
    chk("len_err", bus.len_err, c != int'(hdr[7:2]));
    step();
    chk("err_hold", bus.err, good_par(hdr, n) != par);
    chk("pd_hold", bus.parity_done, 1);
  endtask
  initial begin
    int n, full_at;
    logic [7:0] hdr, par;
    logic [5:0] len;
    reset = 1; bus.pkt_valid = 0; bus.data_in = 0; idle();
    step(); step();
    chk("rst_dout", bus.dout, 0);
    chk("rst_pd", bus.parity_done, 0);
    chk("rst_lpv", bus.low_pkt_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_len_err", bus.len_err, 0);
    reset = 0;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_pkt(8'h0D, 3, 8'h0D, -1);
    send_pkt(8'h0D, 3, 8'hFF, -1);
    send_pkt(8'h0D, 3, 8'h0D, 1);
    send_pkt(8'h11, 3, 8'h11, -1);
    send_pkt(8'h02, 0, 8'h02, -1);
    // pkt_valid falls while the FIFO is full: LAF must finish the packet
    idle(); bus.detect_add = 1; bus.pkt_valid = 1; bus.data_in = 8'h09; step(); idle();
    bus.lfd_state = 1; step(); idle();
    bus.ld_state = 1; bus.data_in = 8'h11; step();
    bus.data_in = 8'h22; step();
    bus.fifo_full = 1; bus.pkt_valid = 0; bus.data_in = 8'h3A; step(); idle();
    chk("lvf_lpv", bus.low_pkt_valid, 1);
    chk("lvf_pd_wait", bus.parity_done, 0);
    chk("lvf_dout_hold", bus.dout, 8'h22);
    bus.full_state = 1; bus.fifo_full = 1; step(); idle();
    bus.laf_state = 1; step(); idle();
    chk("lvf_pd", bus.parity_done, 1);
    chk("lvf_dout", bus.dout, 8'h3A);
    bus.rst_int_reg = 1; step(); idle();
    chk("lvf_lpv_clr", bus.low_pkt_valid, 0);
    bus.ld_state = 1; bus.pkt_valid = 0; bus.rst_int_reg = 1; step(); idle();
    chk("lpv_clr_wins", bus.low_pkt_valid, 0);
    // reset in the middle of a packet
    bus.detect_add = 1; bus.pkt_valid = 1; bus.data_in = 8'h0D; step(); idle();
    bus.lfd_state = 1; step(); idle();
    bus.ld_state = 1; bus.data_in = 8'h11; step();
    reset = 1; step(); reset = 0; idle();
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_pd", bus.parity_done, 0);
    chk("mid_rst_lpv", bus.low_pkt_valid, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_len_err", bus.len_err, 0);
    send_pkt(8'h0D, 3, 8'h0D, -1);
    // count saturation: 191 bytes would wrap a 7-bit counter back to 63
    for (int i = 0; i < 191; i++) pay[i] = 8'($urandom);
    send_pkt(8'hFE, 191, good_par(8'hFE, 191), -1);
    for (int k = 0; k < 30; k++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      len = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 7)) : 6'(n);
      hdr = {len, 2'($urandom)};
      par = good_par(hdr, n) ^ (($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      full_at = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      send_pkt(hdr, n, par, full_at);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
